// File: rtl/adc_mux_scheduler.sv
// Two-input ADC mux sequencer: drives the select line, blanks a settling window after
// every select change, then block-averages 2^LOG2_AVG samples per channel frame.
module adc_mux_scheduler #(
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned LOG2_AVG      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [13:0] adc_i,
   output logic        user_cntr,
   output logic [13:0] data_a_o,
   output logic        valid_a_o,
   output logic [13:0] data_b_o,
   output logic        valid_b_o,
   output logic        busy_o
);

   localparam int ACC_W = 14 + LOG2_AVG;
   localparam int SMP_W = LOG2_AVG + 1;
   localparam logic [SMP_W-1:0] SMP_LAST    = SMP_W'((32'd1 << LOG2_AVG) - 32'd1);
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACQ    = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic                     sel_q, sel_d;
   logic [7:0]               settle_cnt_q, settle_cnt_d;
   logic [SMP_W-1:0]         smp_cnt_q, smp_cnt_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [13:0]              data_a_q, data_a_d;
   logic [13:0]              data_b_q, data_b_d;
   logic                     valid_a_q, valid_a_d;
   logic                     valid_b_q, valid_b_d;
   logic signed [ACC_W-1:0]  adc_ext_s;
   logic signed [ACC_W-1:0]  acc_sum_s;
   logic                     fixed_sel_s;

   assign adc_ext_s   = ACC_W'($signed(adc_i));
   assign acc_sum_s   = acc_q + adc_ext_s;
   // Fixed modes: 00 selects A (1), 01 selects B (0).
   assign fixed_sel_s = ~mode[0];

   // Next-state, select, accumulator and result logic.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      settle_cnt_d = settle_cnt_q;
      smp_cnt_d    = smp_cnt_q;
      acc_d        = acc_q;
      data_a_d     = data_a_q;
      data_b_d     = data_b_q;
      valid_a_d    = 1'b0;
      valid_b_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               sel_d        = (mode == 2'b01) ? 1'b0 : 1'b1;
               settle_cnt_d = 8'd0;
               state_d      = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               acc_d     = '0;
               smp_cnt_d = '0;
               state_d   = ST_ACQ;
            end else begin
               settle_cnt_d = settle_cnt_q + 8'd1;
            end
         end
         ST_ACQ: begin
            if (smp_cnt_q == SMP_LAST) begin
               // Frame boundary: publish floor average, then re-sample mode.
               if (sel_q) begin
                  data_a_d  = acc_sum_s[LOG2_AVG +: 14];
                  valid_a_d = 1'b1;
               end else begin
                  data_b_d  = acc_sum_s[LOG2_AVG +: 14];
                  valid_b_d = 1'b1;
               end
               acc_d        = '0;
               smp_cnt_d    = '0;
               settle_cnt_d = 8'd0;
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (mode[1]) begin
                  sel_d   = ~sel_q;
                  state_d = ST_SETTLE;
               end else if (fixed_sel_s != sel_q) begin
                  sel_d   = fixed_sel_s;
                  state_d = ST_SETTLE;
               end else begin
                  state_d = ST_ACQ;
               end
            end else if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               acc_d     = acc_sum_s;
               smp_cnt_d = smp_cnt_q + SMP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b1;
         settle_cnt_q <= 8'd0;
         smp_cnt_q    <= '0;
         acc_q        <= '0;
         data_a_q     <= 14'd0;
         data_b_q     <= 14'd0;
         valid_a_q    <= 1'b0;
         valid_b_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         settle_cnt_q <= settle_cnt_d;
         smp_cnt_q    <= smp_cnt_d;
         acc_q        <= acc_d;
         data_a_q     <= data_a_d;
         data_b_q     <= data_b_d;
         valid_a_q    <= valid_a_d;
         valid_b_q    <= valid_b_d;
      end
   end

   assign user_cntr = sel_q;
   assign data_a_o  = data_a_q;
   assign data_b_o  = data_b_q;
   assign valid_a_o = valid_a_q;
   assign valid_b_o = valid_b_q;
   assign busy_o    = (state_q != ST_IDLE);

endmodule
